// File: rtl/decode_pkg.sv
// Shared field positions, constants and hazard-tracker state encoding for the decode stage.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package decode_pkg;

  // Instruction class field and the load/store class code
  localparam int CLASS_MSB = 27;
  localparam int CLASS_LSB = 25;
  localparam logic [2:0] CLASS_LDST = 3'b010;

  // Load/store L bit (1 = load)
  localparam int L_BIT = 20;

  // Register fields
  localparam int RN_MSB = 19;
  localparam int RN_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 12;
  localparam int RM_MSB = 3;
  localparam int RM_LSB = 0;

  // Load-use hazard tracker states
  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_PEND = 1'b1
  } hz_state_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write register file with PC substitution and write-first bypass.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none; a write is taken whenever wr_en is high.
module regfile_2r1w #(
  parameter int DATA_W    = 32,
  parameter int NREG      = 16,
  parameter int ADDR_W    = 4,
  parameter int PC_IDX    = 15,
  parameter int PC_OFFSET = 8
) (
  input  logic              clk_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] rd1_idx,
  input  logic [ADDR_W-1:0] rd2_idx,
  output logic [DATA_W-1:0] rd1_dat,
  output logic [DATA_W-1:0] rd2_dat,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_dat
);

  logic [DATA_W-1:0] mem [NREG];
  logic [DATA_W-1:0] pc_rd;

  // PC reads see the pipelined PC value, not the fetch address
  assign pc_rd = pc_i + DATA_W'(PC_OFFSET);

  // Store writes; the PC slot and out-of-range indices have no storage
  always_ff @(posedge clk_i) begin
    if (wr_en && (wr_addr != ADDR_W'(PC_IDX)) && (int'(wr_addr) < NREG)) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read port 1: PC, then same-cycle writeback, then storage
  always_comb begin
    rd1_dat = '0;
    if (rd1_idx == ADDR_W'(PC_IDX)) begin
      rd1_dat = pc_rd;
    end else if (wr_en && (wr_addr == rd1_idx)) begin
      rd1_dat = wr_dat;
    end else if (int'(rd1_idx) < NREG) begin
      rd1_dat = mem[rd1_idx];
    end
  end

  // Read port 2: same priority as port 1
  always_comb begin
    rd2_dat = '0;
    if (rd2_idx == ADDR_W'(PC_IDX)) begin
      rd2_dat = pc_rd;
    end else if (wr_en && (wr_addr == rd2_idx)) begin
      rd2_dat = wr_dat;
    end else if (int'(rd2_idx) < NREG) begin
      rd2_dat = mem[rd2_idx];
    end
  end

endmodule

// File: rtl/decode_stage_pr.sv
// Decode stage: field decode, operand read, load-use hazard tracking, execute-stage pipeline register.
// Latency: one cycle from decode inputs to registered outputs; stall_o and flush_o are combinational.
// Backpressure: stall_i freezes all output registers and the hazard counter; hazards raise stall_o and insert bubbles.
module decode_stage_pr #(
  parameter int DATA_W          = 32,
  parameter int NREG            = 16,
  parameter int ADDR_W          = 4,
  parameter int PC_IDX          = 15,
  parameter int PC_OFFSET       = 8,
  parameter int LOAD_USE_STALLS = 1,
  parameter int CNT_W           = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [31:0]       inst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic              wb_en_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [DATA_W-1:0] pc_o,
  output logic [DATA_W-1:0] r1_o,
  output logic [DATA_W-1:0] r2_o,
  output logic [ADDR_W-1:0] r1_addr_o,
  output logic [ADDR_W-1:0] r2_addr_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              is_load_o,
  output logic              stall_o,
  output logic              flush_o
);
  import decode_pkg::*;

  logic [2:0]        cls;
  logic              is_ldst;
  logic              is_ld;
  logic [ADDR_W-1:0] rn_idx;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] rm_idx;
  logic [ADDR_W-1:0] r1_idx;
  logic [ADDR_W-1:0] r2_idx;
  logic [DATA_W-1:0] r1_dat;
  logic [DATA_W-1:0] r2_dat;

  hz_state_t         state;
  logic [ADDR_W-1:0] ld_rd;
  logic [CNT_W-1:0]  cnt;
  logic              hazard;
  logic              issue_ld;

  assign cls     = inst_i[CLASS_MSB:CLASS_LSB];
  assign is_ldst = (cls == CLASS_LDST);
  assign is_ld   = is_ldst & inst_i[L_BIT];
  assign rn_idx  = ADDR_W'(inst_i[RN_MSB:RN_LSB]);
  assign rd_idx  = ADDR_W'(inst_i[RD_MSB:RD_LSB]);
  assign rm_idx  = ADDR_W'(inst_i[RM_MSB:RM_LSB]);

  // Load/store reads its data register through port 1; ALU ops read rm there
  assign r1_idx = is_ldst ? rd_idx : rm_idx;
  assign r2_idx = rn_idx;

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .ADDR_W   (ADDR_W),
    .PC_IDX   (PC_IDX),
    .PC_OFFSET(PC_OFFSET)
  ) u_regfile (
    .clk_i  (clk_i),
    .pc_i   (pc_i),
    .rd1_idx(r1_idx),
    .rd2_idx(r2_idx),
    .rd1_dat(r1_dat),
    .rd2_dat(r2_dat),
    .wr_en  (wb_en_i),
    .wr_addr(wb_addr_i),
    .wr_dat (wb_data_i)
  );

  // A PC destination never blocks: PC reads are substituted, not forwarded from the load
  assign hazard = (state == ST_LOAD_PEND) && valid_i &&
                  ((r1_idx == ld_rd) || (r2_idx == ld_rd)) &&
                  (ld_rd != ADDR_W'(PC_IDX));
  assign issue_ld = ~hazard & valid_i & is_ld;

  assign stall_o = stall_i | (hazard & ~flush_i);
  assign flush_o = flush_i;

  // Hazard tracker: arm on an issuing load, count down unstalled cycles, re-arm on back-to-back loads
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= ST_IDLE;
      ld_rd <= '0;
      cnt   <= '0;
    end else if (flush_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (!stall_i) begin
      if (issue_ld) begin
        state <= ST_LOAD_PEND;
        ld_rd <= rd_idx;
        cnt   <= CNT_W'(LOAD_USE_STALLS);
      end else if (state == ST_LOAD_PEND) begin
        if (cnt <= CNT_W'(1)) begin
          state <= ST_IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

  // Execute-stage pipeline register: flush kills, stall holds, hazard bubbles, otherwise advance
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o   <= 1'b0;
      inst_o    <= '0;
      pc_o      <= '0;
      r1_o      <= '0;
      r2_o      <= '0;
      r1_addr_o <= '0;
      r2_addr_o <= '0;
      rd_addr_o <= '0;
      is_load_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (!stall_i) begin
      valid_o   <= hazard ? 1'b0 : valid_i;
      inst_o    <= inst_i;
      pc_o      <= pc_i;
      r1_o      <= r1_dat;
      r2_o      <= r2_dat;
      r1_addr_o <= r1_idx;
      r2_addr_o <= r2_idx;
      rd_addr_o <= rd_idx;
      is_load_o <= is_ld;
    end
  end

endmodule

// File: tb/tb_decode_stage_pr.sv
// Bench for decode_stage_pr: two instances (1 and 2 load-use bubbles) share one stimulus stream.
// Latency: checks registered outputs one cycle after inputs, combinational outputs in-cycle.
// Backpressure: stimulus ignores stall_o; the reference model predicts each instance independently.
module tb_decode_stage_pr;

  localparam int LUS_A = 1;
  localparam int LUS_B = 2;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_i, inst_i, wb_data_i;
  logic        valid_i, flush_i, stall_i, wb_en_i;
  logic [3:0]  wb_addr_i;

  logic [1:0]       valid_w, is_load_w, stall_w, flush_w;
  logic [1:0][31:0] inst_w, pc_w, r1_w, r2_w;
  logic [1:0][3:0]  r1a_w, r2a_w, rda_w;

  always #5 clk_i = ~clk_i;

  decode_stage_pr #(.LOAD_USE_STALLS(LUS_A)) dut_a (
    .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_i), .inst_i(inst_i), .valid_i(valid_i),
    .flush_i(flush_i), .stall_i(stall_i), .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i),
    .wb_en_i(wb_en_i), .valid_o(valid_w[0]), .inst_o(inst_w[0]), .pc_o(pc_w[0]),
    .r1_o(r1_w[0]), .r2_o(r2_w[0]), .r1_addr_o(r1a_w[0]), .r2_addr_o(r2a_w[0]),
    .rd_addr_o(rda_w[0]), .is_load_o(is_load_w[0]), .stall_o(stall_w[0]), .flush_o(flush_w[0])
  );

  decode_stage_pr #(.LOAD_USE_STALLS(LUS_B)) dut_b (
    .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_i), .inst_i(inst_i), .valid_i(valid_i),
    .flush_i(flush_i), .stall_i(stall_i), .wb_data_i(wb_data_i), .wb_addr_i(wb_addr_i),
    .wb_en_i(wb_en_i), .valid_o(valid_w[1]), .inst_o(inst_w[1]), .pc_o(pc_w[1]),
    .r1_o(r1_w[1]), .r2_o(r2_w[1]), .r1_addr_o(r1a_w[1]), .r2_addr_o(r2a_w[1]),
    .rd_addr_o(rda_w[1]), .is_load_o(is_load_w[1]), .stall_o(stall_w[1]), .flush_o(flush_w[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: architectural registers, per-instance pending-load tracking and expected outputs
  logic [31:0] m_reg [16];
  int          m_left [2];
  logic [3:0]  m_dest [2];
  logic        e_valid [2];
  logic        e_ld [2];
  logic [31:0] e_inst [2];
  logic [31:0] e_pc [2];
  logic [31:0] e_r1 [2];
  logic [31:0] e_r2 [2];
  logic [3:0]  e_r1a [2];
  logic [3:0]  e_r2a [2];
  logic [3:0]  e_rda [2];

  function automatic int lus_of(input int k);
    return (k == 0) ? LUS_A : LUS_B;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] idx);
    if (idx == 4'd15) return pc_i + 32'd8;
    if (wb_en_i && wb_addr_i == idx) return wb_data_i;
    return m_reg[idx];
  endfunction

  function automatic logic m_ldst();
    return inst_i[27:25] == 3'b010;
  endfunction

  function automatic logic [3:0] m_src1();
    return m_ldst() ? inst_i[15:12] : inst_i[3:0];
  endfunction

  function automatic logic m_hz(input int k);
    if (m_left[k] == 0 || !valid_i || m_dest[k] == 4'd15) return 1'b0;
    return (m_src1() == m_dest[k]) || (inst_i[19:16] == m_dest[k]);
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 2; k++) begin
      m_left[k] = 0; m_dest[k] = 4'd0; e_valid[k] = 1'b0; e_ld[k] = 1'b0;
      e_inst[k] = '0; e_pc[k] = '0; e_r1[k] = '0; e_r2[k] = '0;
      e_r1a[k] = '0; e_r2a[k] = '0; e_rda[k] = '0;
    end
  endtask

  task automatic chk_out(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.valid[%0d]", tag, k), valid_w[k], e_valid[k]);
      chk($sformatf("%s.inst[%0d]", tag, k), inst_w[k], e_inst[k]);
      chk($sformatf("%s.pc[%0d]", tag, k), pc_w[k], e_pc[k]);
      chk($sformatf("%s.r1[%0d]", tag, k), r1_w[k], e_r1[k]);
      chk($sformatf("%s.r2[%0d]", tag, k), r2_w[k], e_r2[k]);
      chk($sformatf("%s.r1a[%0d]", tag, k), r1a_w[k], e_r1a[k]);
      chk($sformatf("%s.r2a[%0d]", tag, k), r2a_w[k], e_r2a[k]);
      chk($sformatf("%s.rda[%0d]", tag, k), rda_w[k], e_rda[k]);
      chk($sformatf("%s.isld[%0d]", tag, k), is_load_w[k], e_ld[k]);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] in, input logic [31:0] pc,
                       input logic fl, input logic st, input logic we,
                       input logic [3:0] wa, input logic [31:0] wd);
    valid_i = v; inst_i = in; pc_i = pc; flush_i = fl; stall_i = st;
    wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
  endtask

  // Called at a negedge with inputs already driven: checks in-cycle outputs, advances model, checks registers
  task automatic step(input string tag);
    logic hz;
    logic ld;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.stall_o[%0d]", tag, k), stall_w[k], stall_i | (m_hz(k) & ~flush_i));
      chk($sformatf("%s.flush_o[%0d]", tag, k), flush_w[k], flush_i);
    end
    for (int k = 0; k < 2; k++) begin
      if (flush_i) begin
        e_valid[k] = 1'b0;
        m_left[k] = 0;
      end else if (!stall_i) begin
        hz = m_hz(k);
        ld = m_ldst() & inst_i[20];
        e_valid[k] = valid_i & ~hz;
        e_inst[k] = inst_i;
        e_pc[k] = pc_i;
        e_r1a[k] = m_src1();
        e_r2a[k] = inst_i[19:16];
        e_rda[k] = inst_i[15:12];
        e_r1[k] = m_read(m_src1());
        e_r2[k] = m_read(inst_i[19:16]);
        e_ld[k] = ld;
        if (!hz && valid_i && ld) begin
          m_dest[k] = inst_i[15:12];
          m_left[k] = lus_of(k);
        end else if (m_left[k] > 0) begin
          m_left[k] = m_left[k] - 1;
        end
      end
    end
    if (wb_en_i && wb_addr_i != 4'd15) m_reg[wb_addr_i] = wb_data_i;
    @(posedge clk_i);
    @(negedge clk_i);
    chk_out(tag);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before the next clock
  task automatic reset_mid(input string tag);
    wb_en_i = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    m_clear();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.rst_stall[%0d]", tag, k), stall_w[k], stall_i);
      chk($sformatf("%s.rst_valid[%0d]", tag, k), valid_w[k], 1'b0);
      chk($sformatf("%s.rst_r1[%0d]", tag, k), r1_w[k], 32'd0);
      chk($sformatf("%s.rst_inst[%0d]", tag, k), inst_w[k], 32'd0);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    chk_out(tag);
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom_range(0, 5));
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] x = $urandom;
    x[27:25] = ($urandom_range(0, 2) == 0) ? 3'b010 : 3'($urandom_range(0, 1) * 4);
    x[19:16] = rnd_reg();
    x[15:12] = rnd_reg();
    x[3:0]   = rnd_reg();
    return x;
  endfunction

  localparam logic [31:0] ADD_R2_R1_R3 = 32'hE0812003;
  localparam logic [31:0] ADD_PC_READ  = 32'hE08F2003;
  localparam logic [31:0] ADD_RM4      = 32'hE0812004;
  localparam logic [31:0] LDR_R4_R1    = 32'hE5914000;
  localparam logic [31:0] ADD_R5_R4_R0 = 32'hE0845000;
  localparam logic [31:0] ADD_R5_R6_R7 = 32'hE0865007;

  initial begin
    reset_i = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    m_clear();
    repeat (2) @(negedge clk_i);
    chk_out("reset");
    reset_i = 1'b0;

    // Preload the register file; r1=5 and r3=7 for the first directed case
    for (int i = 0; i < 15; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 4'(i),
            (i == 1) ? 32'd5 : (i == 3) ? 32'd7 : $urandom);
      step("preload");
    end

    // Mid-cycle reset, then a plain ALU op
    reset_mid("rst1");
    drive(1'b1, ADD_R2_R1_R3, 32'h40, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("add");
    chk("add.valid", valid_w[0], 1'b1);
    chk("add.r2", r2_w[0], 32'd5);
    chk("add.r1", r1_w[0], 32'd7);
    chk("add.rd", rda_w[0], 4'd2);

    // PC read, and a write to r15 does not disturb it
    drive(1'b1, ADD_PC_READ, 32'h100, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("pcrd");
    chk("pcrd.r2", r2_w[0], 32'h108);
    drive(1'b0, '0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd15, 32'hDEAD);
    step("pcwr");
    drive(1'b1, ADD_PC_READ, 32'h200, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("pcrd2");
    chk("pcrd2.r2", r2_w[1], 32'h208);

    // Write-first bypass
    drive(1'b1, ADD_RM4, 32'h44, 1'b0, 1'b0, 1'b1, 4'd4, 32'h55);
    step("byp");
    chk("byp.r1", r1_w[0], 32'h55);

    // Load-use: one bubble on instance A, two on instance B
    drive(1'b1, LDR_R4_R1, 32'h50, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("ldr");
    drive(1'b1, ADD_R5_R4_R0, 32'h54, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    #1;
    chk("lu1.stall_a", stall_w[0], 1'b1);
    chk("lu1.stall_b", stall_w[1], 1'b1);
    step("lu1");
    chk("lu1.bubble_a", valid_w[0], 1'b0);
    chk("lu1.bubble_b", valid_w[1], 1'b0);
    #1;
    chk("lu2.stall_a", stall_w[0], 1'b0);
    chk("lu2.stall_b", stall_w[1], 1'b1);
    step("lu2");
    chk("lu2.issue_a", valid_w[0], 1'b1);
    chk("lu2.bubble_b", valid_w[1], 1'b0);
    step("lu3");
    chk("lu3.issue_b", valid_w[1], 1'b1);
    drive(1'b1, LDR_R4_R1, 32'h60, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("ldr2");
    drive(1'b1, ADD_R5_R6_R7, 32'h64, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    #1;
    chk("indep.stall_a", stall_w[0], 1'b0);
    chk("indep.stall_b", stall_w[1], 1'b0);
    step("indep");

    // Downstream stall holds outputs and freezes the hazard counter
    drive(1'b1, LDR_R4_R1, 32'h70, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("ldr3");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ADD_R5_R4_R0, 32'h74, 1'b0, 1'b1, 1'b0, 4'd0, '0);
      step("hold");
      chk("hold.valid_a", valid_w[0], 1'b1);
      chk("hold.inst_a", inst_w[0], LDR_R4_R1);
    end
    drive(1'b1, ADD_R5_R4_R0, 32'h74, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    #1;
    chk("frozen.stall_a", stall_w[0], 1'b1);
    step("frozen");

    // Flush with stall and a pending hazard
    drive(1'b1, LDR_R4_R1, 32'h80, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("ldr4");
    drive(1'b1, ADD_R5_R4_R0, 32'h84, 1'b1, 1'b1, 1'b0, 4'd0, '0);
    #1;
    chk("fl.stall_a", stall_w[0], 1'b1);
    chk("fl.flush_o", flush_w[0], 1'b1);
    step("fl");
    chk("fl.valid_a", valid_w[0], 1'b0);
    drive(1'b1, ADD_R5_R4_R0, 32'h84, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    #1;
    chk("fl.idle_b", stall_w[1], 1'b0);
    step("postfl");

    // Flush and hazard without downstream stall: no stall request
    drive(1'b1, LDR_R4_R1, 32'h90, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("ldr5");
    drive(1'b1, ADD_R5_R4_R0, 32'h94, 1'b1, 1'b0, 1'b0, 4'd0, '0);
    #1;
    chk("flhz.stall_b", stall_w[1], 1'b0);
    step("flhz");

    // Reset while a load is pending clears the hazard at once
    drive(1'b1, LDR_R4_R1, 32'hA0, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    step("ldr6");
    drive(1'b1, ADD_R5_R4_R0, 32'hA4, 1'b0, 1'b0, 1'b0, 4'd0, '0);
    reset_mid("rst2");

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 8, rnd_inst(), $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), $urandom);
      step("rnd");
      if (i == 1500) reset_mid("rst3");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_pr.md
Name: decode_stage_pr

Overview:
Parametrised decode stage for the ARM-subset pipeline, sitting between fetch and execute.
- Selects the two source registers and reads them from an internal 2-read/1-write register file.
- Writes back with a write-first bypass and returns PC+offset for PC reads.
- Registers the operands, honours downstream stall and flush, and detects load-use hazards itself, requesting fetch stalls for a programmable number of cycles.

Parameters:
- DATA_W, 32, datapath and register width.
- NREG, 16, number of architectural registers.
- ADDR_W, 4, register index width; must satisfy 2**ADDR_W >= NREG.
- PC_IDX, 15, register index that reads as PC.
- PC_OFFSET, 8, value added to pc_i on a PC read.
- LOAD_USE_STALLS, 1, bubbles inserted after a load (1..3).
- CNT_W, 2, stall counter width.

Ports:
- clk_i  in  1  clock, rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- pc_i  in  DATA_W  PC of the instruction in decode.
- inst_i  in  32  instruction in decode.
- valid_i  in  1  inst_i is valid.
- flush_i  in  1  squash the instruction in decode.
- stall_i  in  1  downstream (execute) stall.
- wb_data_i  in  DATA_W  writeback data.
- wb_addr_i  in  ADDR_W  writeback register index.
- wb_en_i  in  1  writeback enable.
- valid_o  out  1  execute-stage instruction valid.
- inst_o  out  32  registered instruction.
- pc_o  out  DATA_W  registered PC.
- r1_o  out  DATA_W  registered operand 1.
- r2_o  out  DATA_W  registered operand 2.
- r1_addr_o  out  ADDR_W  registered r1 index.
- r2_addr_o  out  ADDR_W  registered r2 index.
- rd_addr_o  out  ADDR_W  registered destination index.
- is_load_o  out  1  registered instruction is a load.
- stall_o  out  1  stall request to fetch (combinational).
- flush_o  out  1  equals flush_i (combinational pass-through).

Behaviour:
Field decode:
- class = inst_i[27:25]; rn = inst_i[19:16]; rd = inst_i[15:12]; rm = inst_i[3:0].
- r2 index = rn.
- r1 index = rd when class==3'b010 (load/store), otherwise rm.
- load = (class==3'b010) & inst_i[20].

Register read:
- Index PC_IDX returns pc_i + PC_OFFSET, modulo 2**DATA_W.
- Otherwise, if wb_en_i and wb_addr_i equals the read index, return wb_data_i (write-first bypass).
- Otherwise return the stored value.

Register write:
- Stored on the clock edge when wb_en_i=1.
- Writes to PC_IDX, or to an index >= NREG, are ignored.

Output register update, by priority:
1. reset_i: all outputs 0, FSM to IDLE. Register file contents are not reset.
2. flush_i: valid_o<=0, FSM to IDLE, counter<=0.
3. stall_i: every output register holds its value, including valid_o.
4. hazard: valid_o<=0 (bubble); the data fields load the decoded values.
5. else: all fields load from the decode inputs; valid_o<=valid_i.
- Latency: inputs reach the outputs one cycle later.

Hazard tracker FSM:
- IDLE: an issue (rule 5 with valid_i & load) goes to LOAD_PEND; ld_rd<=rd and cnt<=LOAD_USE_STALLS.
- LOAD_PEND: cnt decrements on each cycle with stall_i=0. When cnt reaches 0, go to IDLE.
  - A load issuing on the same cycle reloads ld_rd and cnt and stays in LOAD_PEND.
- hazard = LOAD_PEND & valid_i & (r1 index==ld_rd | r2 index==ld_rd) & ld_rd!=PC_IDX.
- stall_o = stall_i | (hazard & ~flush_i).
- While stall_i=1, the counter does not decrement.

Boundary cases:
- Reset mid-LOAD_PEND clears the hazard immediately, since reset is asynchronous.
- Flush and hazard in the same cycle: no stall.
- Writeback to the hazard register while in LOAD_PEND: the stall still completes its count.

Decomposition:
decode_pkg holds:
- class field position and CLASS_LDST=3'b010;
- L-bit position;
- rn/rd/rm field positions;
- FSM state encoding (IDLE, LOAD_PEND).

One sub-module, regfile_2r1w, parametrised by DATA_W/NREG/ADDR_W/PC_IDX/PC_OFFSET. It contains the PC substitution and the write-first bypass. Hazard FSM, address selection and pipeline registers stay in decode_stage_pr.

Test Plan:
1. Reset asserted mid-cycle -> all outputs 0 immediately. ADD r2,r1,r3 (0xE0812003), valid, with r1=5 and r3=7 preloaded -> next cycle valid_o=1, r2_o=5, r1_o=7, rd_addr_o=2.
2. PC read: inst with rn=15, pc_i=0x100 -> r2_o=0x108. A write to r15 with 0xDEAD leaves a later PC read at pc_i+8.
3. Bypass: wb_en_i=1, wb_addr_i=4, wb_data_i=0x55 in the same cycle as an inst reading rm=4 -> r1_o=0x55.
4. Load-use: LDR r4,[r1] then ADD r5,r4,r0, LOAD_USE_STALLS=1 -> stall_o=1 for one cycle, one bubble (valid_o=0), then ADD issues. Repeat with LOAD_USE_STALLS=2 -> two bubbles. A dependent-free instruction after the load -> no stall.
5. stall_i=1 for 3 cycles with valid data held -> outputs and valid_o unchanged, stall_o=1, hazard counter frozen.
6. flush_i together with stall_i and a pending hazard -> valid_o=0 next cycle, stall_o=stall_i only, FSM in IDLE, flush_o=1 in the same cycle.
